// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_pkg: shared ALU_ctr encodings, FSM state type and magnitude helper for the multiply/divide unit
//   DATA_W        default operand width
//   ALU_CTR_MULT  control-unit code for MULT (must track the decoder)
//   ALU_CTR_DIV   control-unit code for DIV  (must track the decoder)
//   state_t       IDLE / CALC / SIGN / DONE
//   abs_val()     two's-complement magnitude; -2^(W-1) maps to 2^(W-1) read as unsigned
package muldiv_pkg;
  localparam int DATA_W = 32;
  localparam logic [3:0] ALU_CTR_MULT = 4'b1000;
  localparam logic [3:0] ALU_CTR_DIV = 4'b1001;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: issue/operand/result bundle between the decode stage and the multiply/divide unit
//   master: issue, alu_ctr, flush, operand_a, operand_b out; stall, busy, done, result_hi, result_lo, div_by_zero in
//   slave : the mirror image, used by muldiv_sequencer
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             issue;
  logic [3:0]       alu_ctr;
  logic             flush;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  modport master (output issue, alu_ctr, flush, operand_a, operand_b,
                  input stall, busy, done, result_hi, result_lo, div_by_zero);
  modport slave (input issue, alu_ctr, flush, operand_a, operand_b,
                 output stall, busy, done, result_hi, result_lo, div_by_zero);
endinterface

// File: rtl/muldiv_sequencer_step.sv
// muldiv_step: one combinational iteration of unsigned shift-add multiply or restoring divide
//   i_op        OP_MULT or OP_DIV
//   i_hi, i_lo  MULT: upper/lower accumulator halves; DIV: partial remainder / quotient-dividend register
//   i_b         divisor magnitude, or the addend magnitude for MULT
//   o_hi, o_lo  register values after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  // MULT keeps the multiplier in the low half: add on its LSB, then shift the whole 2W accumulator right.
  // DIV shifts the next dividend bit into the remainder; when it fits, the difference is below i_b so W bits suffice.
  always_comb begin
    w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_ge = w_shift >= {1'b0, i_b};
    w_diff = w_shift[WIDTH-1:0] - i_b;
    o_hi = i_op == OP_MULT ? w_sum[WIDTH:1] : w_ge ? w_diff : w_shift[WIDTH-1:0];
    o_lo = i_op == OP_MULT ? {w_sum[0], i_lo[WIDTH-1:1]} : {i_lo[WIDTH-2:0], w_ge};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed MULT/DIV unit that stalls the pipeline and returns results on HI/LO
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   mb (slave)    issue/alu_ctr/flush/operands in; stall/busy/done/result_hi/result_lo/div_by_zero out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic clock,
  input logic reset,
  muldiv_sequencer_if.slave mb
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic [WIDTH-1:0]   r_hi, r_lo, r_b, r_res_hi, r_res_lo;
  logic [WIDTH-1:0]   w_hi, w_lo, w_fix_hi, w_fix_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q, r_neg_r, r_dbz;
  logic               w_is_div, w_valid_op, w_accept_req, w_accept, w_b_zero, w_dbz, w_busy;
  logic [2*WIDTH-1:0] w_prod;
  assign w_is_div = mb.alu_ctr == ALU_CTR_DIV;
  assign w_valid_op = mb.alu_ctr == ALU_CTR_MULT || w_is_div;
  assign w_accept_req = mb.issue && r_state == IDLE && w_valid_op;
  // flush wins over a same-cycle accept
  assign w_accept = w_accept_req && !mb.flush;
  assign w_b_zero = mb.operand_b == '0;
  assign w_dbz = w_is_div && w_b_zero;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_op(r_op),
    .i_hi(r_hi),
    .i_lo(r_lo),
    .i_b (r_b),
    .o_hi(w_hi),
    .o_lo(w_lo)
  );
  // sign fix-up: MULT negates the full 2W product, DIV negates quotient and remainder independently
  always_comb begin
    w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_fix_hi = r_op == OP_MULT ? w_prod[2*WIDTH-1:WIDTH] : r_neg_r ? -r_hi : r_hi;
    w_fix_lo = r_op == OP_MULT ? w_prod[WIDTH-1:0] : r_neg_q ? -r_lo : r_lo;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = mb.flush ? IDLE
           : r_state == IDLE ? (w_accept ? (w_dbz ? DONE : CALC) : IDLE)
           : r_state == CALC ? (r_cnt == CNT_LAST ? SIGN : CALC)
           : r_state == SIGN ? DONE : IDLE;
  end
  always_comb begin
    w_busy = r_state == CALC || r_state == SIGN;
    mb.busy = w_busy;
    mb.done = r_state == DONE;
    mb.stall = w_busy || w_accept_req;
  end
  assign mb.result_hi = r_res_hi;
  assign mb.result_lo = r_res_lo;
  assign mb.div_by_zero = r_dbz;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_op <= OP_MULT;
      r_hi <= '0;
      r_lo <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else if (w_accept) begin
      r_op <= w_is_div ? OP_DIV : OP_MULT;
      r_hi <= '0;
      r_lo <= abs_val(mb.operand_a);
      r_b <= abs_val(mb.operand_b);
      r_neg_q <= mb.operand_a[WIDTH-1] ^ mb.operand_b[WIDTH-1];
      r_neg_r <= mb.operand_a[WIDTH-1];
      r_cnt <= CNT_INIT;
      r_dbz <= w_dbz;
      // divide-by-zero skips CALC/SIGN, so its results are written at accept
      if (w_dbz) begin
        r_res_hi <= mb.operand_a;
        r_res_lo <= '1;
      end
    end else if (!mb.flush && r_state == CALC) begin
      r_hi <= w_hi;
      r_lo <= w_lo;
      r_cnt <= r_cnt - 1'b1;
    end else if (!mb.flush && r_state == SIGN) begin
      r_res_hi <= w_fix_hi;
      r_res_lo <= w_fix_lo;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative signed multiply/divide unit with its own sequencing FSM. It executes the MULT (ALU_ctr 4'b1000) and DIV (ALU_ctr 4'b1001) operations that the control unit decodes.
- Sits beside the single-cycle ALU. It stalls the PC and register write-back while it iterates, then returns the results on a HI/LO pair.

Parameters:
- WIDTH, 32, operand width in bits; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- issue  input  1  instruction in decode is valid this cycle.
- alu_ctr  input  4  ALU_ctr from control unit. 4'b1000 = MULT, 4'b1001 = DIV; other codes are ignored.
- flush  input  1  synchronous abort of the operation in flight.
- operand_a  input  WIDTH  rs value: multiplicand or dividend, two's complement.
- operand_b  input  WIDTH  rt value: multiplier or divisor, two's complement.
- stall  output  1  freeze PC/pipeline; combinational.
- busy  output  1  operation in flight, registered.
- done  output  1  one-cycle pulse: results valid.
- result_hi  output  WIDTH  MULT: product[2W-1:W]. DIV: remainder.
- result_lo  output  WIDTH  MULT: product[W-1:0]. DIV: quotient.
- div_by_zero  output  1  set with done when DIV had operand_b == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; busy, done, div_by_zero = 0.
  - result_hi, result_lo = 0; counter = 0.
- States: IDLE, CALC, SIGN, DONE.
- Accept condition: issue=1, state=IDLE, alu_ctr ∈ {1000, 1001}.
  - On accept, latch |a|, |b|, op, and the result signs (MULT: sign_a^sign_b; DIV: quotient sign_a^sign_b, remainder sign_a).
  - Counter = WIDTH. Go to CALC, except DIV with b==0, which goes directly to DONE.
- CALC, one iteration per cycle:
  - MULT: radix-2 shift-add on a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract.
  - Counter decrements each cycle; at counter==1 go to SIGN. CALC lasts exactly WIDTH cycles.
- SIGN (1 cycle): apply two's-complement negation per the latched signs; write result_hi/result_lo. Go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
  - result_hi/result_lo hold until the next accepted operation reaches SIGN (or DONE for divide-by-zero).
- Latency: accept at edge 0 → done high in cycle WIDTH+2 (cycle 34 for WIDTH=32). Divide-by-zero: done high in cycle 1.
- busy = 1 in CALC and SIGN. busy = 0 in IDLE and DONE.
- stall = busy | (state==IDLE & accept condition). The issuing instruction therefore freezes in the accept cycle and advances in the DONE cycle, where it captures the results.
- Issue in any non-IDLE state (including DONE) is ignored; no queuing.
- Divide-by-zero: result_lo = all ones, result_hi = operand_a (unmodified), div_by_zero = 1. The flag clears at the next accept.
- Overflow: -2^(W-1) / -1 gives quotient = 0x80000000, remainder = 0 (natural wrap). No flag.
- MULT full-range: -2^(W-1) * -2^(W-1) = 0x40000000_00000000, exact.
- flush: from any state go to IDLE next edge. No done; results unchanged; busy=0 next cycle. flush has priority over accept in the same cycle.
- Reset mid-operation: immediate clear. No done is ever produced for the aborted operation.

Decomposition:
- Shared package (muldiv_pkg):
  - ALU_CTR_MULT=4'b1000, ALU_CTR_DIV=4'b1001. These must match the control unit's encoding.
  - State enum IDLE/CALC/SIGN/DONE.
  - Function abs_val(WIDTH).
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: op, accumulator, remainder/quotient registers, |b|.
  - Outputs: next accumulator/remainder/quotient.
  - The FSM, counter, sign fix-up and registers stay in muldiv_sequencer.

Test Plan:
1. MULT 7 × -3 → done at cycle 34; result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB; stall high cycles 0–33, low in 34.
2. DIV 100 / 7 → result_lo=14, result_hi=2. DIV -7 / 2 → result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF; div_by_zero=0.
3. DIV 5 / 0 → done in cycle 1; result_lo=0xFFFFFFFF, result_hi=5, div_by_zero=1. A following MULT 2×3 clears the flag and gives lo=6, hi=0.
4. Edge values:
   - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
   - MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
5. MULT started, reset asserted at cycle 10 → outputs zero immediately, no done pulse. MULT started, flush at cycle 10 → IDLE at cycle 11, no done, results hold prior values.
6. Issue with alu_ctr=4'b0010 → no stall, stays IDLE. Second MULT issued at cycle 5 and in the DONE cycle of an operation in flight → ignored; only one done pulse.
